// File: rtl/mips_wb_pkg.sv
// Shared definitions for the MIPS register-file writeback arbiter.
//   AW, DW      : default register address / data widths
//   REG_ZERO    : architectural zero register (writes to it are dropped)
//   wb_entry_t  : one queued writeback {valid, wreg, data}
//   reg_onehot  : decode a register number into a one-hot bitmap
package mips_wb_pkg;

    localparam int AW = 5;
    localparam int DW = 32;

    localparam logic [AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] wreg;
        logic [DW-1:0] data;
    } wb_entry_t;

    function automatic logic [(1<<AW)-1:0] reg_onehot(input logic [AW-1:0] r);
        logic [(1<<AW)-1:0] v;
        v    = '0;
        v[r] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the two writeback sources, the arbiter and the
// register file / hazard unit.
//   a_*      : ALU writeback (always accepted)
//   b_*      : MDU / load writeback with valid/ready handshake
//   wr_*     : register-file write port (wrreg / wrdata / write)
//   pending  : bitmap of registers with a live queued write
//   count    : port-B queue occupancy (squashed entries included)
// Modports: master = sources / consumers side, slave = arbiter side.
interface regfile_wb_arbiter_if #(
    parameter int DEPTH = 4,
    parameter int AW    = mips_wb_pkg::AW,
    parameter int DW    = mips_wb_pkg::DW
);

    logic                  a_valid;
    logic [AW-1:0]         a_reg;
    logic [DW-1:0]         a_data;

    logic                  b_valid;
    logic                  b_ready;
    logic [AW-1:0]         b_reg;
    logic [DW-1:0]         b_data;

    logic                  wr_en;
    logic [AW-1:0]         wr_reg;
    logic [DW-1:0]         wr_data;

    logic [(1<<AW)-1:0]    pending;
    logic [$clog2(DEPTH):0] count;

    modport master (
        output a_valid, a_reg, a_data,
        output b_valid, b_reg, b_data,
        input  b_ready,
        input  wr_en, wr_reg, wr_data,
        input  pending, count
    );

    modport slave (
        input  a_valid, a_reg, a_data,
        input  b_valid, b_reg, b_data,
        output b_ready,
        output wr_en, wr_reg, wr_data,
        output pending, count
    );

endinterface

// File: rtl/wb_fifo.sv
// Port-B writeback queue.
//   push / push_entry   : enqueue one entry at the tail
//   pop                 : dequeue the head (head is valid to read this cycle)
//   squash / squash_reg : clear the valid bit of every entry targeting squash_reg
//   head                : current head entry
//   empty / count       : occupancy (squashed entries still occupy a slot)
//   pending             : OR of decoded registers over live (valid) entries
// Popped slots have their valid bit cleared, so every valid bit in storage
// belongs to a live entry and pending needs no occupancy masking.
module wb_fifo
    import mips_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  wb_entry_t              push_entry,
    input  logic                   pop,
    input  logic                   squash,
    input  logic [AW-1:0]          squash_reg,
    output wb_entry_t              head,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [(1<<AW)-1:0]     pending
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = 1;
    localparam logic [PW:0]   CNT_ONE = 1;

    wb_entry_t     mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (squash) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (mem[i].wreg == squash_reg) begin
                        mem[i].valid <= 1'b0;
                    end
                end
            end
            if (pop) begin
                mem[rd_ptr].valid <= 1'b0;
                rd_ptr            <= rd_ptr + PTR_ONE;
            end
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem[i].valid) begin
                pending = pending | reg_onehot(mem[i].wreg);
            end
        end
        pending[0] = 1'b0;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-side master for the 32x32 MIPS register file.
// Merges the single-cycle ALU writeback (port A, never stalled) with the
// multi-cycle MDU/load writeback (port B, queued in wb_fifo) onto one
// registered write port, and exports the pending-write bitmap.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : regfile_wb_arbiter_if.slave (a_*, b_*, wr_*, pending, count)
// Build option:
//   WB_BYPASS_EN : when the queue is empty and port A is idle, an accepted
//                  port-B write loads the output register directly instead
//                  of passing through the queue.
module regfile_wb_arbiter
    import mips_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_wb_arbiter_if.slave  bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = DEPTH[CW-1:0];

    logic               a_hit;
    logic               b_acc;
    logic               b_live;
    logic               b_same;
    logic               bypass;
    logic               push;
    logic               pop;
    logic               fifo_empty;
    logic [CW-1:0]      fifo_count;
    logic [(1<<AW)-1:0] fifo_pending;
    wb_entry_t          head;
    wb_entry_t          push_entry;

    logic               wr_en_q;
    logic [AW-1:0]      wr_reg_q;
    logic [DW-1:0]      wr_data_q;

    // A write to r0 is not a request, so it never blocks the queue drain.
    assign a_hit  = bus.a_valid && (bus.a_reg != REG_ZERO);

    // Ready looks only at the registered count; a same-cycle pop does not
    // reopen a full queue.
    assign bus.b_ready = (fifo_count < FULL_CNT);
    assign b_acc  = bus.b_valid && bus.b_ready;
    assign b_live = b_acc && (bus.b_reg != REG_ZERO);

    // Same destination as a concurrent A write: A is newer, B is dropped.
    assign b_same = a_hit && (bus.a_reg == bus.b_reg);

`ifdef WB_BYPASS_EN
    assign bypass = b_live && fifo_empty && !a_hit;
`else
    assign bypass = 1'b0;
`endif

    assign push = b_live && !b_same && !bypass;
    assign pop  = !a_hit && !fifo_empty;

    assign push_entry = '{valid: 1'b1, wreg: bus.b_reg, data: bus.b_data};

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .squash     (a_hit),
        .squash_reg (bus.a_reg),
        .head       (head),
        .empty      (fifo_empty),
        .count      (fifo_count),
        .pending    (fifo_pending)
    );

    // A squashed head still pops, leaving a one-cycle bubble with wr_en low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q   <= 1'b0;
            wr_reg_q  <= '0;
            wr_data_q <= '0;
        end else if (a_hit) begin
            wr_en_q   <= 1'b1;
            wr_reg_q  <= bus.a_reg;
            wr_data_q <= bus.a_data;
        end else if (bypass) begin
            wr_en_q   <= 1'b1;
            wr_reg_q  <= bus.b_reg;
            wr_data_q <= bus.b_data;
        end else if (!fifo_empty) begin
            wr_en_q   <= head.valid;
            wr_reg_q  <= head.wreg;
            wr_data_q <= head.data;
        end else begin
            wr_en_q   <= 1'b0;
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_reg  = wr_reg_q;
    assign bus.wr_data = wr_data_q;
    assign bus.count   = fifo_count;
    assign bus.pending = fifo_pending;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, latency, full/drain,
// WAW squash, same-edge A/B, r0 handling and reset with queued entries.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] pm;

    regfile_wb_arbiter_if #(.DEPTH(4)) bus ();

    regfile_wb_arbiter #(.DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [4:0] r, input logic [31:0] d);
        bus.a_valid = v;
        bus.a_reg   = r;
        bus.a_data  = d;
    endtask

    task automatic drive_b(input logic v, input logic [4:0] r, input logic [31:0] d);
        bus.b_valid = v;
        bus.b_reg   = r;
        bus.b_data  = d;
    endtask

    task automatic idle();
        drive_a(1'b0, 5'd0, 32'h0);
        drive_b(1'b0, 5'd0, 32'h0);
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_en", 32'(bus.wr_en), 32'h0);
        chk("rst_wr_reg", 32'(bus.wr_reg), 32'h0);
        chk("rst_wr_data", bus.wr_data, 32'h0);
        chk("rst_count", 32'(bus.count), 32'h0);
        chk("rst_pending", bus.pending, 32'h0);
        rst_n = 1'b1;
        #2;
        chk("rst_b_ready", 32'(bus.b_ready), 32'h1);

        // ---- latency: B r5 = 0x1234 into an idle arbiter
        drive_b(1'b1, 5'd5, 32'h1234);
        step();
        idle();
`ifdef WB_BYPASS_EN
        chk("lat_wr_en", 32'(bus.wr_en), 32'h1);
        chk("lat_wr_reg", 32'(bus.wr_reg), 32'd5);
        chk("lat_wr_data", bus.wr_data, 32'h1234);
        chk("lat_count", 32'(bus.count), 32'h0);
`else
        chk("lat_wr_en_k", 32'(bus.wr_en), 32'h0);
        chk("lat_count_k", 32'(bus.count), 32'h1);
        chk("lat_pending_k", bus.pending, 32'h20);
        step();
        chk("lat_wr_en", 32'(bus.wr_en), 32'h1);
        chk("lat_wr_reg", 32'(bus.wr_reg), 32'd5);
        chk("lat_wr_data", bus.wr_data, 32'h1234);
        chk("lat_count", 32'(bus.count), 32'h0);
        chk("lat_pending", bus.pending, 32'h0);
`endif
        step();
        chk("lat_idle_wr_en", 32'(bus.wr_en), 32'h0);
        chk("lat_hold_wr_reg", 32'(bus.wr_reg), 32'd5);
        chk("lat_hold_wr_data", bus.wr_data, 32'h1234);

        // ---- full and drain: A r8 held for 6 cycles, B r9..r12 queued
        for (int i = 0; i < 6; i++) begin
            drive_a(1'b1, 5'd8, 32'h80 + 32'(i));
            if (i < 4) drive_b(1'b1, 5'(9 + i), 32'h90 + 32'(i));
            else       drive_b(1'b1, 5'd13, 32'hDD);
            step();
            chk("full_wr_en", 32'(bus.wr_en), 32'h1);
            chk("full_wr_reg", 32'(bus.wr_reg), 32'd8);
            chk("full_wr_data", bus.wr_data, 32'h80 + 32'(i));
            chk("full_count", 32'(bus.count), 32'((i < 4) ? i + 1 : 4));
        end
        chk("full_b_ready", 32'(bus.b_ready), 32'h0);
        chk("full_pending", bus.pending, 32'h0000_1E00);
        idle();
        for (int j = 0; j < 4; j++) begin
            if (j == 0) chk("drain_b_ready_full_pop", 32'(bus.b_ready), 32'h0);
            step();
            pm = 32'h0;
            for (int r = 10 + j; r <= 12; r++) pm[r] = 1'b1;
            chk("drain_wr_en", 32'(bus.wr_en), 32'h1);
            chk("drain_wr_reg", 32'(bus.wr_reg), 32'(9 + j));
            chk("drain_wr_data", bus.wr_data, 32'h90 + 32'(j));
            chk("drain_count", 32'(bus.count), 32'(3 - j));
            chk("drain_pending", bus.pending, pm);
        end
        step();
        chk("drain_done_wr_en", 32'(bus.wr_en), 32'h0);

        // ---- squash: B r7=0xAA queued behind A r6, then A r7=0xBB
        drive_a(1'b1, 5'd6, 32'h66);
        drive_b(1'b1, 5'd7, 32'hAA);
        step();
        chk("sq_count_q", 32'(bus.count), 32'h1);
        chk("sq_pending_q", bus.pending, 32'h80);
        drive_a(1'b1, 5'd7, 32'hBB);
        drive_b(1'b0, 5'd0, 32'h0);
        step();
        chk("sq_a_wr_en", 32'(bus.wr_en), 32'h1);
        chk("sq_a_wr_reg", 32'(bus.wr_reg), 32'd7);
        chk("sq_a_wr_data", bus.wr_data, 32'hBB);
        chk("sq_pending_cleared", bus.pending, 32'h0);
        chk("sq_count_kept", 32'(bus.count), 32'h1);
        idle();
        step();
        chk("sq_bubble_wr_en", 32'(bus.wr_en), 32'h0);
        chk("sq_bubble_wr_data", bus.wr_data, 32'hAA);
        chk("sq_bubble_count", 32'(bus.count), 32'h0);

        // ---- same-edge A and B to r3
        drive_a(1'b1, 5'd3, 32'h1);
        drive_b(1'b1, 5'd3, 32'h2);
        chk("same_b_ready", 32'(bus.b_ready), 32'h1);
        step();
        idle();
        chk("same_wr_en", 32'(bus.wr_en), 32'h1);
        chk("same_wr_reg", 32'(bus.wr_reg), 32'd3);
        chk("same_wr_data", bus.wr_data, 32'h1);
        chk("same_count", 32'(bus.count), 32'h0);
        chk("same_pending", bus.pending, 32'h0);
        step();
        chk("same_no_b_wr_en", 32'(bus.wr_en), 32'h0);

        // ---- register 0 on both ports
        drive_a(1'b1, 5'd0, 32'h55);
        drive_b(1'b1, 5'd0, 32'h66);
        step();
        chk("r0_wr_en", 32'(bus.wr_en), 32'h0);
        chk("r0_count", 32'(bus.count), 32'h0);
        chk("r0_pending", bus.pending, 32'h0);
        idle();
        step();
        chk("r0_wr_en_after", 32'(bus.wr_en), 32'h0);

        // ---- A to r0 does not block the queue drain
        drive_a(1'b1, 5'd2, 32'h22);
        drive_b(1'b1, 5'd4, 32'h44);
        step();
        chk("a0_count_q", 32'(bus.count), 32'h1);
        drive_a(1'b1, 5'd0, 32'h99);
        drive_b(1'b0, 5'd0, 32'h0);
        step();
        chk("a0_drain_wr_en", 32'(bus.wr_en), 32'h1);
        chk("a0_drain_wr_reg", 32'(bus.wr_reg), 32'd4);
        chk("a0_drain_wr_data", bus.wr_data, 32'h44);
        chk("a0_drain_count", 32'(bus.count), 32'h0);
        idle();
        step();

        // ---- reset mid-stream with 3 queued entries
        for (int i = 0; i < 3; i++) begin
            drive_a(1'b1, 5'd1, 32'h11);
            drive_b(1'b1, 5'(20 + i), 32'hC0 + 32'(i));
            step();
        end
        chk("mid_count_q", 32'(bus.count), 32'h3);
        chk("mid_pending_q", bus.pending, 32'h0070_0000);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_wr_en", 32'(bus.wr_en), 32'h0);
        chk("mid_rst_count", 32'(bus.count), 32'h0);
        chk("mid_rst_pending", bus.pending, 32'h0);
        idle();
        #2;
        rst_n = 1'b1;
        chk("mid_rel_b_ready", 32'(bus.b_ready), 32'h1);
        step();
        chk("mid_after_wr_en", 32'(bus.wr_en), 32'h0);
        chk("mid_after_count", 32'(bus.count), 32'h0);
        chk("mid_after_pending", bus.pending, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Write-side master for the 32x32 MIPS register file. Merges two writeback sources into the file's single write port (`wrreg`/`wrdata`/`write`):
  - the single-cycle ALU path (port A);
  - the multi-cycle mul/div/load path (port B).
- Port A is never stalled. Port B is buffered in a small FIFO and drained in idle write slots.
- Exports a pending-write bitmap so the hazard unit can stall readers of registers with queued writes.

Parameters:
- DEPTH, 4, port-B FIFO entries (power of 2, ≥2)
- AW, 5, register address width
- DW, 32, data width

Ports:
- clk  input  1  system clock; outputs update on posedge (register file samples on negedge)
- rst_n  input  1  asynchronous active-low reset
- a_valid  input  1  ALU writeback request; always accepted
- a_reg  input  AW  ALU destination register
- a_data  input  DW  ALU result
- b_valid  input  1  MDU/load writeback request
- b_ready  output  1  arbiter can accept port B this cycle
- b_reg  input  AW  port-B destination register
- b_data  input  DW  port-B result
- wr_en  output  1  register-file write strobe (drives `write`)
- wr_reg  output  AW  drives `wrreg`
- wr_data  output  DW  drives `wrdata`
- pending  output  32  bit r = 1 while a live FIFO entry targets register r
- count  output  $clog2(DEPTH)+1  FIFO occupancy, including squashed entries

Behaviour:
- **Reset** (async on rst_n low): `wr_en`=0, `wr_reg`=0, `wr_data`=0, FIFO empty, `count`=0, `pending`=0, all entry valid bits cleared. A reset mid-drain discards all queued entries.
- **Ready:** `b_ready` = (`count` < DEPTH), combinational from registered `count` only; it does not depend on a same-cycle pop.
  - Full with a pop: `b_ready` stays 0 that cycle.
  - After reset: `b_ready`=1.
- **Port B acceptance:** B accepted at posedge when `b_valid` && `b_ready`.
  - `b_reg`≠0: entry {reg, data, valid=1} is pushed.
  - `b_reg`=0: the request is accepted but not pushed.
- **Output register** (each posedge, priority order):
  1. `a_valid` && `a_reg`≠0: `wr_en`=1, `wr_reg`=`a_reg`, `wr_data`=`a_data`. Latency 1.
  2. Else if FIFO not empty: pop head. `wr_en` = head.valid, `wr_reg`/`wr_data` = head fields. A squashed head yields a one-cycle bubble with `wr_en`=0.
  3. Else `wr_en`=0. `wr_reg`/`wr_data` hold their previous values.
- **Port A with `a_reg`=0:** treated as no request for priority purposes, so the FIFO may drain that cycle.
- **Port B latency:** accepted at edge k, earliest write at edge k+1 after acceptance (`wr_en` high during cycle k+1), given an empty FIFO and no A.
- **WAW squash:** when A is accepted with `a_reg`=X≠0, every FIFO entry with reg==X has its valid bit cleared at the same edge. Port A is architecturally newer.
- **Same-edge A/B, same register:** A wins. B is accepted (counts as a handshake) but not pushed.
- **Same-edge A/B, different registers:** A is written, B is pushed.
- **Push and pop on the same edge:** allowed when not full. `count` is unchanged.
- **Pointer wrap:** read/write pointers are mod DEPTH. Full/empty are derived from `count`.
- **`pending`:** combinational OR over valid entries (decoded reg). Bit 0 is always 0. Register-file forwarding of the in-flight `wr_*` is not this block's job.

Optional Feature:
- Macro: `WB_BYPASS_EN`.
- Defined: if FIFO empty, `a_valid` low (or `a_reg`=0), and B accepted with `b_reg`≠0, B loads the output register directly at the acceptance edge (latency 1) and is not pushed.
- Undefined: B always goes through the FIFO (latency 2 as above).
- All other rules are identical in both builds.

Decomposition:
- Shared package `mips_wb_pkg`:
  - AW/DW defaults;
  - `REG_ZERO`=5'd0;
  - typedef `wb_entry_t` {valid, reg[AW-1:0], data[DW-1:0]}.
- One sub-module, `wb_fifo`:
  - DEPTH entries of `wb_entry_t`;
  - push, pop, squash-by-reg, count, pending-bitmap outputs.
- The top level holds the priority mux, output register and bypass.

Test Plan:
- **Reset:** assert rst_n low mid-stream with 3 queued entries → `wr_en`=0, `count`=0, `pending`=0 immediately; after release `b_ready`=1.
- **Latency:** B write r5=0x1234 into an idle arbiter → `wr_en`=1, `wr_reg`=5, `wr_data`=0x1234 after two edges (one edge with `WB_BYPASS_EN`).
- **Full and drain:** hold `a_valid` with r8 writes for 6 cycles while pushing B to r9..r12 → `count` reaches 4 and `b_ready`=0. Release A → r9..r12 are written in order on 4 consecutive cycles and `pending` bits clear one per cycle.
- **Squash:** queue B r7=0xAA, then A writes r7=0xBB → `wr_data` 0xBB for r7, followed by one `wr_en`=0 bubble; `pending`[7] clears at the A edge.
- **Same-edge A and B to r3:** A=1, B=2 → only r3=1 is written, `count` unchanged, handshake completes.
- **Register 0:** A and B requests targeting r0 → `wr_en` never asserted, `count` stays 0, `pending`[0]=0.
